// File: rtl/fifo_ctrl_distributed_if.sv
// Handshake and RAM-port bundle for fifo_ctrl_distributed.
// master: the FIFO controller. slave: producer/consumer/RAM side.
// Optional error-reporting signals exist only when FIFO_CTRL_ERR_EN is defined.
interface fifo_ctrl_distributed_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 2);

  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          wea;
  logic [AW-1:0] addra;
  logic          reb;
  logic [AW-1:0] addrb;
  logic [LW-1:0] level;
  logic          almost_full;
`ifdef FIFO_CTRL_ERR_EN
  logic          overflow_err;
  logic [7:0]    drop_cnt;

  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, wea, addra, reb, addrb, level, almost_full,
           overflow_err, drop_cnt
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, wea, addra, reb, addrb, level, almost_full,
           overflow_err, drop_cnt
  );
`else
  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, wea, addra, reb, addrb, level, almost_full
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, wea, addra, reb, addrb, level, almost_full
  );
`endif
endinterface

// File: rtl/fifo_ctrl_distributed.sv
// Single-clock first-word-fall-through FIFO controller driving an external
// simple dual-port distributed RAM (async read + one output register).
// Capacity is DEPTH + 1: DEPTH words in the RAM plus the RAM output register.
// Optional feature macro: FIFO_CTRL_ERR_EN adds sticky overflow_err and a
// saturating 8-bit drop_cnt of writes offered while full.
module fifo_ctrl_distributed #(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  fifo_ctrl_distributed_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 2);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [LW-1:0] AFULL_C  = LW'(AFULL_LVL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          almost_full_q;
  logic [LW-1:0] level_d;
  logic          ready;
  logic          wr_en;
  logic          load;

  // Ready depends only on RAM occupancy, never on out_ready, so a full RAM
  // refuses writes even in a cycle that also loads the output register.
  assign ready = !reset && (ram_cnt_q != FULL_CNT);
  assign wr_en = bus.in_valid && ready;
  assign load  = !reset && (ram_cnt_q != '0) && (!out_valid_q || bus.out_ready);

  assign bus.in_ready    = ready;
  assign bus.wea         = wr_en;
  assign bus.addra       = wr_ptr_q;
  assign bus.reb         = load;
  assign bus.addrb       = rd_ptr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.level       = LW'(ram_cnt_q) + LW'(out_valid_q);
  assign bus.almost_full = almost_full_q;

  // Next-state: pointers, RAM word count, output-register valid and level.
  always_comb begin
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = load  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    if (wr_en && !load) begin
      ram_cnt_d = ram_cnt_q + (AW + 1)'(1);
    end else if (!wr_en && load) begin
      ram_cnt_d = ram_cnt_q - (AW + 1)'(1);
    end
    out_valid_d = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    level_d     = LW'(ram_cnt_d) + LW'(out_valid_d);
  end

  // State register; almost_full is registered from the next-state level.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= (level_d >= AFULL_C);
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic       overflow_err_q;
  logic [7:0] drop_cnt_q;

  assign bus.overflow_err = overflow_err_q;
  assign bus.drop_cnt     = drop_cnt_q;

  // Sticky flag and saturating counter of writes offered while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else if (bus.in_valid && !ready) begin
      overflow_err_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_distributed.sv
// Bench for fifo_ctrl_distributed: includes a behavioural model of the
// distributed RAM (async read, registered output) and a queue-based FIFO model.
module tb_fifo_ctrl_distributed;
  localparam int DEPTH     = 16;
  localparam int AFULL_LVL = 12;
  localparam int AW        = $clog2(DEPTH);
  localparam int LW        = $clog2(DEPTH + 2);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [7:0] mem [DEPTH];
  logic [7:0] dob;

  always #5 clk = ~clk;

  fifo_ctrl_distributed_if #(.DEPTH(DEPTH)) bus ();

  fifo_ctrl_distributed #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: write port and registered read port, same clock.
  always @(posedge clk) begin
    if (bus.wea) mem[bus.addra] <= din;
    if (bus.reb) dob <= mem[bus.addrb];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int seq      = 0;

  // Reference model: words stored in RAM, and the output register contents.
  int  ram_q[$];
  bit  m_ov;
  int  m_head;
  int  wr_total, rd_total;
  int  m_drops;
  bit  m_err;

  bit  cur_rst, cur_v, cur_r;
  int  cur_d;
  bit  e_in_ready, e_wr, e_load, e_af;
  int  e_level;
  logic [LW+4:0] exp_vec, obs_vec;

  // Apply inputs at the falling edge and compute what the DUT must show now.
  task automatic drive(input bit rst, input bit v, input bit r, input int d);
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = v;
    bus.out_ready = r;
    din           = 8'(d);
    cur_rst = rst; cur_v = v; cur_r = r; cur_d = d & 8'hFF;
    e_in_ready = !rst && (ram_q.size() != DEPTH);
    e_wr       = v && e_in_ready;
    e_load     = !rst && (ram_q.size() != 0) && (!m_ov || r);
    e_level    = ram_q.size() + int'(m_ov);
    e_af       = (e_level >= AFULL_LVL);
    exp_vec    = {e_in_ready, e_wr, e_load, m_ov, LW'(e_level), e_af};
    #1;
    obs_vec    = {bus.in_ready, bus.wea, bus.reb, bus.out_valid, bus.level, bus.almost_full};
  endtask

  // Advance the model across the rising edge.
  task automatic step();
    @(posedge clk);
    if (cur_rst) begin
      ram_q.delete();
      m_ov = 0; wr_total = 0; rd_total = 0; m_drops = 0; m_err = 0;
    end else begin
      if (cur_v && !e_in_ready) begin
        m_err = 1;
        if (m_drops < 255) m_drops++;
      end
      if (e_load) begin
        m_head = ram_q.pop_front();
        m_ov   = 1;
        rd_total++;
      end else if (cur_r) begin
        m_ov = 0;
      end
      if (e_wr) begin
        ram_q.push_back(cur_d);
        wr_total++;
      end
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0); step();
    drive(1, 1, 1, 8'h11);
    n_checks++;
    if ({bus.in_ready, bus.wea, bus.reb} !== 3'b000)
      $display("FAIL reset_gating got=%b exp=000", {bus.in_ready, bus.wea, bus.reb});
    else n_pass++;
    step();
    drive(0, 0, 0, 0);
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL reset_state got=%h exp=%h", obs_vec, exp_vec);
    else n_pass++;
    n_checks++;
    if (bus.level !== '0 || bus.out_valid !== 1'b0 || bus.almost_full !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_flags got lvl=%0d ov=%b af=%b rdy=%b exp 0/0/0/1",
               bus.level, bus.out_valid, bus.almost_full, bus.in_ready);
    else n_pass++;
    step();
  endtask

  task automatic test_single_write();
    drive(0, 1, 0, 8'hA5);
    n_checks++;
    if (bus.wea !== 1'b1 || bus.addra !== AW'(0))
      $display("FAIL single_wr got wea=%b addra=%0d exp 1/0", bus.wea, bus.addra);
    else n_pass++;
    step();
    drive(0, 0, 0, 0);
    n_checks++;
    if (bus.reb !== 1'b1 || bus.addrb !== AW'(0) || bus.out_valid !== 1'b0 || bus.level !== LW'(1))
      $display("FAIL single_reb got reb=%b addrb=%0d ov=%b lvl=%0d exp 1/0/0/1",
               bus.reb, bus.addrb, bus.out_valid, bus.level);
    else n_pass++;
    step();
    drive(0, 0, 0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.level !== LW'(1) || bus.in_ready !== 1'b1 || dob !== 8'hA5)
      $display("FAIL single_out got ov=%b lvl=%0d rdy=%b dob=%h exp 1/1/1/a5",
               bus.out_valid, bus.level, bus.in_ready, dob);
    else n_pass++;
    step();
    drive(0, 0, 1, 0); step();
  endtask

  task automatic test_fill();
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(0, 1, 0, seq);
      seq++;
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL fill_vec i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      else n_pass++;
      step();
    end
    drive(0, 1, 0, 8'h99);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.wea !== 1'b0 || bus.level !== LW'(DEPTH + 1) || bus.almost_full !== 1'b1)
      $display("FAIL fill_full got rdy=%b wea=%b lvl=%0d af=%b exp 0/0/%0d/1",
               bus.in_ready, bus.wea, bus.level, bus.almost_full, DEPTH + 1);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    for (int i = 0; i < 50; i++) begin
      drive(0, 1, 1, seq);
      if (e_wr) seq++;
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL b2b_vec i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      else n_pass++;
      n_checks++;
      if (dob !== 8'(m_head) || bus.out_valid !== 1'b1)
        $display("FAIL b2b_data i=%0d got dob=%h ov=%b exp %h/1", i, dob, bus.out_valid, 8'(m_head));
      else n_pass++;
      if (bus.out_valid === 1'b1) pops++;
      step();
    end
    n_checks++;
    if (pops !== 50) $display("FAIL b2b_rate got=%0d pops exp=50", pops);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] a0, b0;
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, seq); seq++; step();
    end
    drive(0, 0, 0, 0); step();
    drive(0, 1, 1, seq); seq++;
    a0 = bus.addra; b0 = bus.addrb;
    n_checks++;
    if (bus.wea !== 1'b1 || bus.reb !== 1'b1 || bus.level !== LW'(6))
      $display("FAIL simul_en got wea=%b reb=%b lvl=%0d exp 1/1/6", bus.wea, bus.reb, bus.level);
    else n_pass++;
    step();
    drive(0, 0, 0, 0);
    n_checks++;
    if (bus.level !== LW'(6) || bus.addra !== AW'(a0 + 1) || bus.addrb !== AW'(b0 + 1) || ram_q.size() != 5)
      $display("FAIL simul_after got lvl=%0d addra=%0d addrb=%0d exp 6/%0d/%0d",
               bus.level, bus.addra, bus.addrb, AW'(a0 + 1), AW'(b0 + 1));
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int lv[2] = '{9, 14};
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0); step();
      for (int i = 0; i < lv[k]; i++) begin
        drive(0, 1, 0, seq); seq++; step();
      end
      drive(0, 0, 0, 0); step();
      drive(1, 1, 1, 0);
      n_checks++;
      if (bus.wea !== 1'b0 || bus.reb !== 1'b0 || bus.in_ready !== 1'b0 || bus.level !== LW'(lv[k]))
        $display("FAIL rstmid_during got wea=%b reb=%b rdy=%b lvl=%0d exp 0/0/0/%0d",
                 bus.wea, bus.reb, bus.in_ready, bus.level, lv[k]);
      else n_pass++;
      step();
      drive(0, 0, 0, 0);
      n_checks++;
      if (bus.level !== '0 || bus.out_valid !== 1'b0 || bus.almost_full !== 1'b0)
        $display("FAIL rstmid_after got lvl=%0d ov=%b af=%b exp 0/0/0",
                 bus.level, bus.out_valid, bus.almost_full);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int pv = (i < 300) ? 75 : 35;
      int pr = (i < 300) ? 35 : 75;
      bit rst = ($urandom_range(0, 149) == 0);
      bit v   = ($urandom_range(0, 99) < pv);
      bit r   = ($urandom_range(0, 99) < pr);
      drive(rst, v, r, seq);
      if (e_wr) seq++;
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL rand_vec i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      else n_pass++;
      n_checks++;
      if (bus.addra !== AW'(wr_total % DEPTH) || bus.addrb !== AW'(rd_total % DEPTH))
        $display("FAIL rand_addr i=%0d got %0d/%0d exp %0d/%0d", i, bus.addra, bus.addrb,
                 wr_total % DEPTH, rd_total % DEPTH);
      else n_pass++;
      if (m_ov) begin
        n_checks++;
        if (dob !== 8'(m_head)) $display("FAIL rand_data i=%0d got=%h exp=%h", i, dob, 8'(m_head));
        else n_pass++;
      end
`ifdef FIFO_CTRL_ERR_EN
      n_checks++;
      if (bus.overflow_err !== m_err || bus.drop_cnt !== 8'(m_drops))
        $display("FAIL rand_err i=%0d got %b/%0d exp %b/%0d", i, bus.overflow_err, bus.drop_cnt, m_err, m_drops);
      else n_pass++;
`endif
      step();
    end
  endtask

`ifdef FIFO_CTRL_ERR_EN
  task automatic test_err();
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(0, 1, 0, seq); seq++; step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0); step();
    end
    drive(0, 0, 0, 0);
    n_checks++;
    if (bus.overflow_err !== 1'b1 || bus.drop_cnt !== 8'd3)
      $display("FAIL err_three got %b/%0d exp 1/3", bus.overflow_err, bus.drop_cnt);
    else n_pass++;
    step();
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 0, 0); step();
    end
    drive(0, 0, 0, 0);
    n_checks++;
    if (bus.overflow_err !== 1'b1 || bus.drop_cnt !== 8'd255)
      $display("FAIL err_sat got %b/%0d exp 1/255", bus.overflow_err, bus.drop_cnt);
    else n_pass++;
    step();
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0);
    n_checks++;
    if (bus.overflow_err !== 1'b0 || bus.drop_cnt !== 8'd0)
      $display("FAIL err_reset got %b/%0d exp 0/0", bus.overflow_err, bus.drop_cnt);
    else n_pass++;
    step();
  endtask
`endif

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    din           = '0;
    test_reset();
    test_single_write();
    test_fill();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef FIFO_CTRL_ERR_EN
    test_err();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
